multicycle_control_fsm: RTL

- Main control state machine for the multicycle RISC-V datapath.
- Decodes the 7-bit opcode held in the IR and sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives the 3-bit ALU_Op field consumed by the ALU control unit, plus all mux-select and write-enable strobes.
- Stalls on a memory ready handshake, flags illegal opcodes and counts retired instructions.

---
 rtl/multicycle_control_fsm_if.sv | 40 ++++
 rtl/multicycle_control_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle FSM and the datapath.
// master = control FSM, slave = datapath side.
interface multicycle_control_fsm_if #(
    parameter int INSTRET_WIDTH = 32
);
    logic [6:0]               opcode_i;
    logic                     mem_ready_i;
    logic                     pc_write_o;
    logic                     pc_write_cond_o;
    logic [1:0]               pc_src_o;
    logic                     ir_write_o;
    logic                     mem_read_o;
    logic                     mem_write_o;
    logic                     i_or_d_o;
    logic                     reg_write_o;
    logic [1:0]               mem_to_reg_o;
    logic [1:0]               alu_src_a_o;
    logic [1:0]               alu_src_b_o;
    logic [2:0]               alu_op_o;
    logic                     alu_force_add_o;
    logic [3:0]               state_o;
    logic                     illegal_o;
    logic [INSTRET_WIDTH-1:0] instret_o;

    modport master (
        input  opcode_i, mem_ready_i,
        output pc_write_o, pc_write_cond_o, pc_src_o, ir_write_o,
        output mem_read_o, mem_write_o, i_or_d_o, reg_write_o,
        output mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o,
        output alu_force_add_o, state_o, illegal_o, instret_o
    );

    modport slave (
        output opcode_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_o, pc_src_o, ir_write_o,
        input  mem_read_o, mem_write_o, i_or_d_o, reg_write_o,
        input  mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o,
        input  alu_force_add_o, state_o, illegal_o, instret_o
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RISC-V datapath.
// Moore decode of state; only pc_write and ir_write see mem_ready.
module multicycle_control_fsm #(
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_fsm_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_t                   state_q, state_d;
    logic                     illegal_q;
    logic [INSTRET_WIDTH-1:0] instret_q;
    logic                     retire;
    logic                     pc_write, pc_write_cond, ir_write;
    logic                     mem_read, mem_write, reg_write;
    logic                     i_or_d, force_add;
    logic [1:0]               pc_src, mem_to_reg, src_a, src_b;
    logic [2:0]               alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP)
                illegal_q <= 1'b1;
            if (retire)
                instret_q <= instret_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        i_or_d        = 1'b0;
        force_add     = 1'b0;
        pc_src        = 2'b00;
        mem_to_reg    = 2'b00;
        src_a         = 2'b00;
        src_b         = 2'b00;
        alu_op        = 3'b000;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                src_b     = 2'b01;
                force_add = 1'b1;
                if (bus.mem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/JAL target is parked in ALUOut here.
                src_a     = 2'b10;
                src_b     = 2'b10;
                force_add = 1'b1;
                case (bus.opcode_i)
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                src_a = 2'b01;
                src_b = 2'b10;
                if (bus.opcode_i == OP_SW) begin
                    alu_op  = 3'b011;
                    state_d = S_MEM_WR;
                end else begin
                    alu_op  = 3'b110;
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (bus.mem_ready_i)
                    state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (bus.mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                src_a   = 2'b01;
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a   = 2'b01;
                src_b   = 2'b10;
                alu_op  = 3'b001;
                state_d = S_ALU_WB;
            end
            S_LUI: begin
                src_b   = 2'b10;
                alu_op  = 3'b010;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                src_a         = 2'b01;
                alu_op        = 3'b100;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                pc_src     = 2'b01;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR: begin
                src_a      = 2'b01;
                src_b      = 2'b10;
                alu_op     = 3'b101;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Strobes are killed combinationally so reset acts within the cycle.
    assign bus.pc_write_o      = pc_write & ~reset;
    assign bus.pc_write_cond_o = pc_write_cond & ~reset;
    assign bus.ir_write_o      = ir_write & ~reset;
    assign bus.mem_read_o      = mem_read & ~reset;
    assign bus.mem_write_o     = mem_write & ~reset;
    assign bus.reg_write_o     = reg_write & ~reset;
    assign bus.pc_src_o        = pc_src;
    assign bus.i_or_d_o        = i_or_d;
    assign bus.mem_to_reg_o    = mem_to_reg;
    assign bus.alu_src_a_o     = src_a;
    assign bus.alu_src_b_o     = src_b;
    assign bus.alu_op_o        = alu_op;
    assign bus.alu_force_add_o = force_add;
    assign bus.state_o         = state_q;
    assign bus.illegal_o       = illegal_q;
    assign bus.instret_o       = instret_q;
endmodule
